// File: rtl/shift_add_mul_pipe.sv
// Pipelined shift-and-add multiplier: one register stage of partial products followed by a
// pairwise adder tree, with a single global advance/stall, flush and signed/unsigned mode.
module shift_add_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul_out,
  output logic               busy
);

  localparam int OUT_W  = 2*WIDTH;
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NODES  = 2*WIDTH - 1;

  // All tree nodes live in one flat array; level k starts at 2*WIDTH - (2*WIDTH >> k).
  logic [OUT_W-1:0] node_q [NODES];
  logic [OUT_W-1:0] node_d [NODES];
  logic [LEVELS:0]  valid_q;
  logic [OUT_W-1:0] a_ext;
  logic             advance;

  assign a_ext = mode ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      logic [OUT_W-1:0] shifted;
      assign shifted = a_ext << gi;
      if (gi == WIDTH-1) begin : g_msb
        // The multiplier MSB carries negative weight in signed mode.
        assign node_d[gi] = mul_b[gi] ? (mode ? -shifted : shifted) : '0;
      end else begin : g_lsb
        assign node_d[gi] = mul_b[gi] ? shifted : '0;
      end
    end

    for (genvar gi = 1; gi <= LEVELS; gi++) begin : g_lvl
      localparam int SRC = 2*WIDTH - ((2*WIDTH) >> (gi-1));
      localparam int DST = 2*WIDTH - ((2*WIDTH) >> gi);
      for (genvar gj = 0; gj < (WIDTH >> gi); gj++) begin : g_add
        assign node_d[DST + gj] = node_q[SRC + 2*gj] + node_q[SRC + 2*gj + 1];
      end
    end
  endgenerate

  assign out_valid = valid_q[LEVELS];
  assign mul_out   = node_q[NODES-1];
  assign busy      = |valid_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q  <= '{default: '0};
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (advance) begin
      node_q  <= node_d;
      valid_q <= {valid_q[LEVELS-1:0], in_valid};
    end
  end

endmodule
